// File: rtl/hms_pkg.sv
// Shared definitions for the hms_alarm_clock block.
//   state_t : edit-state encoding, also driven out on the state port for
//             display blinking (RUN=0 .. ALM_M=5).
//   SEC_MAX, MIN_MAX : last value of the seconds and minutes fields.
//   HRS_W, MS_W      : widths of the hours and the minutes/seconds fields.
package hms_pkg;

    localparam int HRS_W = 5;
    localparam int MS_W  = 6;

    localparam logic [MS_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MS_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        SET_H = 3'd1,
        SET_M = 3'd2,
        SET_S = 3'd3,
        ALM_H = 3'd4,
        ALM_M = 3'd5
    } state_t;

endpackage

// File: rtl/hms_wrap_ctr.sv
// Modulus counter holding 0..MAX. It wraps in both directions.
//   clk, rst_n : system clock and asynchronous active-low reset (clears to 0).
//   inc, dec   : step up / step down. Both high, or both low, holds the value.
//   value      : registered count.
//   at_max     : combinational flag, high while value == MAX. The owner uses
//                it for carries.
module hms_wrap_ctr #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign at_max = (value == MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (inc && !dec) begin
            value <= at_max ? '0 : value + W'(1);
        end else if (dec && !inc) begin
            value <= (value == '0) ? MAX_V : value - W'(1);
        end
    end

endmodule

// File: rtl/hms_alarm_clock.sv
// Hours/minutes/seconds clock that runs from the system clock.
// It has an editable time, an editable alarm, and snooze/stop controls.
//   clk, rst_n      : system clock, asynchronous active-low reset.
//   mode            : pulse. Moves to the next edit state
//                     (RUN->SET_H->SET_M->SET_S->ALM_H->ALM_M->RUN).
//   inc, dec        : pulses. Step the field being edited. No carry.
//   alarm_en        : level. The alarm is armed while this is high.
//   snooze, stop    : pulses. They control a ringing or snoozed alarm.
//   hrs, min, sec   : current time.
//   alm_hrs/alm_min : alarm time.
//   state           : edit-state code.
//   ringing         : alarm is sounding.
//   snoozed         : a snooze re-ring is pending.
// Every output is registered.
module hms_alarm_clock
    import hms_pkg::*;
#(
    parameter int CLK_PER_SEC = 4,
    parameter int HOURS       = 24,
    parameter int SNOOZE_MIN  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             inc,
    input  logic             dec,
    input  logic             alarm_en,
    input  logic             snooze,
    input  logic             stop,
    output logic [HRS_W-1:0] hrs,
    output logic [MS_W-1:0]  min,
    output logic [MS_W-1:0]  sec,
    output logic [HRS_W-1:0] alm_hrs,
    output logic [MS_W-1:0]  alm_min,
    output logic [2:0]       state,
    output logic             ringing,
    output logic             snoozed
);

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

    state_t state_q, state_d;
    logic   in_run;

    // ---------------- edit-state FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (mode) begin
            case (state_q)
                RUN:     state_d = SET_H;
                SET_H:   state_d = SET_M;
                SET_M:   state_d = SET_S;
                SET_S:   state_d = ALM_H;
                ALM_H:   state_d = ALM_M;
                default: state_d = RUN;
            endcase
        end
    end

    assign in_run = (state_q == RUN);
    assign state  = state_q;

    // ---------------- prescaler ----------------
    // The prescaler restarts from 0 on every entry to RUN. The first second
    // after an edit is therefore a full CLK_PER_SEC cycles long.
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = in_run && (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        presc <= '0;
        else if (!in_run || mode || tick)  presc <= '0;
        else                               presc <= presc + PW'(1);
    end

    // ---------------- field counters ----------------
    // mode has priority over inc/dec. A mode press leaves the field unchanged.
    logic e_inc, e_dec;
    logic sec_max, min_max, hrs_max;
    logic alm_hrs_max_unused, alm_min_max_unused;
    logic roll_min;

    assign e_inc    = inc && !mode;
    assign e_dec    = dec && !mode;
    assign roll_min = tick && sec_max;

    hms_wrap_ctr #(.W(MS_W), .MAX(SEC_MAX)) u_sec (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (tick || (state_q == SET_S && e_inc)),
        .dec    (state_q == SET_S && e_dec),
        .value  (sec),
        .at_max (sec_max)
    );

    hms_wrap_ctr #(.W(MS_W), .MAX(MIN_MAX)) u_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (roll_min || (state_q == SET_M && e_inc)),
        .dec    (state_q == SET_M && e_dec),
        .value  (min),
        .at_max (min_max)
    );

    hms_wrap_ctr #(.W(HRS_W), .MAX(HOURS - 1)) u_hrs (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    ((roll_min && min_max) || (state_q == SET_H && e_inc)),
        .dec    (state_q == SET_H && e_dec),
        .value  (hrs),
        .at_max (hrs_max)
    );

    hms_wrap_ctr #(.W(HRS_W), .MAX(HOURS - 1)) u_alm_hrs (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (state_q == ALM_H && e_inc),
        .dec    (state_q == ALM_H && e_dec),
        .value  (alm_hrs),
        .at_max (alm_hrs_max_unused)
    );

    hms_wrap_ctr #(.W(MS_W), .MAX(MIN_MAX)) u_alm_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (state_q == ALM_M && e_inc),
        .dec    (state_q == ALM_M && e_dec),
        .value  (alm_min),
        .at_max (alm_min_max_unused)
    );

    // ---------------- alarm / snooze ----------------
    // Alarm matches look at the hh:mm the clock is about to show. Only a
    // tick that rolls the seconds to 00 can produce a match. ringing can
    // therefore rise on the same edge that shows hh:mm:00.
    logic [HRS_W-1:0] hrs_plus1, nxt_hrs, tgt_hrs, snz_hrs;
    logic [MS_W-1:0]  nxt_min, tgt_min, snz_min;
    logic [MS_W:0]    min_sum;
    logic             alarm_hit, snooze_hit;

    always_comb begin
        hrs_plus1 = hrs_max ? '0 : hrs + HRS_W'(1);
        nxt_min   = min_max ? '0 : min + MS_W'(1);
        nxt_hrs   = min_max ? hrs_plus1 : hrs;

        // Snooze target = current hh:mm + SNOOZE_MIN. It carries at most
        // one hour because SNOOZE_MIN is at most 59.
        min_sum = {1'b0, min} + (MS_W + 1)'(SNOOZE_MIN);
        if (min_sum > {1'b0, MIN_MAX}) begin
            tgt_min = MS_W'(min_sum - ({1'b0, MIN_MAX} + (MS_W + 1)'(1)));
            tgt_hrs = hrs_plus1;
        end else begin
            tgt_min = min_sum[MS_W-1:0];
            tgt_hrs = hrs;
        end
    end

    assign alarm_hit  = roll_min && alarm_en &&
                        (nxt_hrs == alm_hrs) && (nxt_min == alm_min);
    assign snooze_hit = roll_min && snoozed &&
                        (nxt_hrs == snz_hrs) && (nxt_min == snz_min);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ringing <= 1'b0;
            snoozed <= 1'b0;
            snz_hrs <= '0;
            snz_min <= '0;
        end else if (stop || !alarm_en || (in_run && mode)) begin
            ringing <= 1'b0;
            snoozed <= 1'b0;
        end else if (snooze && ringing) begin
            ringing <= 1'b0;
            snoozed <= 1'b1;
            snz_hrs <= tgt_hrs;
            snz_min <= tgt_min;
        end else if (snooze_hit) begin
            ringing <= 1'b1;
            snoozed <= 1'b0;
        end else if (alarm_hit) begin
            ringing <= 1'b1;
        end
    end

endmodule
